// File: rtl/ex_mem_stage_ctrl.sv
// EX->MEM pipeline register with a variable-latency data-memory port.
// Issues at most one load/store per held entry, aligns store data and extends load data.
module ex_mem_stage_ctrl #(
  parameter int unsigned PAY_W    = 42,
  parameter int unsigned ADDR_W   = 32,
  parameter bit          LOAD_EXT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_to_mem_reg_valid,
  output logic              ex_mem_reg_allow_in,
  input  logic [PAY_W-1:0]  in_payload,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_mem_mode,
  input  logic              in_mem_us,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic              flush,
  input  logic              mem_wb_reg_allow_in,
  output logic              mem_to_wb_reg_valid,
  output logic [PAY_W-1:0]  out_payload,
  output logic [31:0]       out_rdata,
  output logic              out_misalign,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  localparam logic [2:0] StEmpty = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWaitR = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [PAY_W-1:0]  payload_q, payload_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [2:0]        mode_q, mode_d;
  logic              us_q, us_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  logic       accept;
  logic       in_misalign;
  logic [1:0] off;

  assign off = addr_q[1:0];

  // Only memory ops can be misaligned; byte accesses never are.
  always_comb begin
    in_misalign = 1'b0;
    if (in_mem_read || in_mem_write) begin
      if (in_mem_mode == 3'd1) begin
        in_misalign = in_addr[0];
      end else if (in_mem_mode != 3'd0) begin
        in_misalign = (in_addr[1:0] != 2'b00);
      end
    end
  end

  always_comb begin
    ex_mem_reg_allow_in = !flush &&
                          ((state_q == StEmpty) || ((state_q == StHold) && mem_wb_reg_allow_in));
    accept = ex_mem_reg_allow_in && ex_to_mem_reg_valid;
  end

  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mode_d      = mode_q;
    us_d        = us_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    misalign_d  = misalign_q;

    case (state_q)
      StIssue: begin
        if (dmem_gnt) begin
          // A granted store is committed even if flushed; a granted load must drain its data.
          if (flush) state_d = mem_write_q ? StEmpty : StDrain;
          else       state_d = mem_write_q ? StHold : StWaitR;
        end else if (flush) begin
          state_d = StEmpty;
        end
      end
      StWaitR: begin
        if (flush) begin
          state_d = dmem_rvalid ? StEmpty : StDrain;
        end else if (dmem_rvalid) begin
          rdata_d = dmem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (flush || mem_wb_reg_allow_in) state_d = StEmpty;
      end
      StDrain: begin
        if (dmem_rvalid) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase

    if (accept) begin
      payload_d   = in_payload;
      mem_read_d  = in_mem_read;
      mem_write_d = in_mem_write;
      mode_d      = in_mem_mode;
      us_d        = in_mem_us;
      addr_d      = in_addr;
      wdata_d     = in_wdata;
      rdata_d     = 32'd0;
      misalign_d  = in_misalign;
      if (in_misalign)                     state_d = StHold;
      else if (in_mem_read || in_mem_write) state_d = StIssue;
      else                                  state_d = StHold;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      payload_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mode_q      <= 3'd0;
      us_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mode_q      <= mode_d;
      us_q        <= us_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    dmem_req  = (state_q == StIssue);
    dmem_we   = dmem_req && mem_write_q;
    dmem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    case (mode_q)
      3'd0: begin
        dmem_wdata = {4{wdata_q[7:0]}};
        dmem_wstrb = 4'b0001 << off;
      end
      3'd1: begin
        dmem_wdata = {2{wdata_q[15:0]}};
        dmem_wstrb = 4'b0011 << off;
      end
      default: begin
        dmem_wdata = wdata_q;
        dmem_wstrb = 4'b1111;
      end
    endcase
    if (!dmem_we) dmem_wstrb = 4'b0000;
  end

  logic [31:0] lane;
  logic [15:0] half;
  logic [31:0] ext;

  always_comb begin
    lane = rdata_q >> {off, 3'b000};
    half = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (mode_q)
      3'd0:    ext = us_q ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      3'd1:    ext = us_q ? {16'd0, half} : {{16{half[15]}}, half};
      default: ext = rdata_q;
    endcase
  end

  always_comb begin
    mem_to_wb_reg_valid = (state_q == StHold);
    out_payload         = payload_q;
    out_misalign        = misalign_q;
    if (mem_read_q && !misalign_q) out_rdata = LOAD_EXT ? ext : rdata_q;
    else                           out_rdata = 32'd0;
  end

endmodule

// File: tb/tb_ex_mem_stage_ctrl.sv
// Directed bench for ex_mem_stage_ctrl: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_ex_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_to_mem_reg_valid;
  logic        ex_mem_reg_allow_in;
  logic [41:0] in_payload;
  logic        in_mem_read, in_mem_write;
  logic [2:0]  in_mem_mode;
  logic        in_mem_us;
  logic [31:0] in_addr, in_wdata;
  logic        flush, mem_wb_reg_allow_in;
  logic        mem_to_wb_reg_valid;
  logic [41:0] out_payload;
  logic [31:0] out_rdata;
  logic        out_misalign;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_mem_stage_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .ex_to_mem_reg_valid (ex_to_mem_reg_valid),
    .ex_mem_reg_allow_in (ex_mem_reg_allow_in),
    .in_payload          (in_payload),
    .in_mem_read         (in_mem_read),
    .in_mem_write        (in_mem_write),
    .in_mem_mode         (in_mem_mode),
    .in_mem_us           (in_mem_us),
    .in_addr             (in_addr),
    .in_wdata            (in_wdata),
    .flush               (flush),
    .mem_wb_reg_allow_in (mem_wb_reg_allow_in),
    .mem_to_wb_reg_valid (mem_to_wb_reg_valid),
    .out_payload         (out_payload),
    .out_rdata           (out_rdata),
    .out_misalign        (out_misalign),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_wstrb          (dmem_wstrb),
    .dmem_gnt            (dmem_gnt),
    .dmem_rvalid         (dmem_rvalid),
    .dmem_rdata          (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [41:0] pay, input logic rd, input logic wr,
                       input logic [2:0] mode, input logic us, input logic [31:0] addr,
                       input logic [31:0] wd);
    ex_to_mem_reg_valid = 1'b1;
    in_payload   = pay;
    in_mem_read  = rd;
    in_mem_write = wr;
    in_mem_mode  = mode;
    in_mem_us    = us;
    in_addr      = addr;
    in_wdata     = wd;
  endtask

  task automatic idle_in();
    ex_to_mem_reg_valid = 1'b0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
  endtask

  // Load from EMPTY: gnt on the gdly-th ISSUE cycle, rvalid the cycle after.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] mode,
                          input logic us, input int gdly, input logic [31:0] rd,
                          input logic [31:0] exp);
    offer(42'h3C, 1'b1, 1'b0, mode, us, addr, 32'd0);
    sample(); chk({tag, "_allow"}, 64'(ex_mem_reg_allow_in), 64'(1));
    adv();
    idle_in();
    for (int i = 0; i < gdly; i++) begin
      dmem_gnt = (i == gdly - 1);
      sample();
      chk({tag, "_req"}, 64'(dmem_req), 64'(1));
      chk({tag, "_we"}, 64'(dmem_we), 64'(0));
      chk({tag, "_addr"}, 64'(dmem_addr), 64'({addr[31:2], 2'b00}));
      adv();
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = rd;
    sample();
    chk({tag, "_noreq_wait"}, 64'(dmem_req), 64'(0));
    chk({tag, "_novalid_wait"}, 64'(mem_to_wb_reg_valid), 64'(0));
    adv();
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'h0;
    sample();
    chk({tag, "_valid"}, 64'(mem_to_wb_reg_valid), 64'(1));
    chk({tag, "_rdata"}, 64'(out_rdata), 64'(exp));
    adv();
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    in_payload = '0; in_mem_mode = 3'd0; in_mem_us = 1'b0; in_addr = '0; in_wdata = '0;
    flush = 1'b0; mem_wb_reg_allow_in = 1'b1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    adv(); adv();
    sample();
    chk("rst_valid", 64'(mem_to_wb_reg_valid), 64'(0));
    chk("rst_req", 64'(dmem_req), 64'(0));
    chk("rst_payload", 64'(out_payload), 64'(0));
    chk("rst_rdata", 64'(out_rdata), 64'(0));
    adv();
    reset = 1'b0;
    adv();

    // 1: back-to-back ALU ops
    offer(42'h11, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    sample(); chk("alu_allow0", 64'(ex_mem_reg_allow_in), 64'(1));
    adv();
    in_payload = 42'h22;
    sample(); chk("alu_v1", 64'(mem_to_wb_reg_valid), 64'(1));
    chk("alu_p1", 64'(out_payload), 64'h11);
    chk("alu_allow1", 64'(ex_mem_reg_allow_in), 64'(1));
    adv();
    in_payload = 42'h33;
    sample(); chk("alu_v2", 64'(mem_to_wb_reg_valid), 64'(1));
    chk("alu_p2", 64'(out_payload), 64'h22);
    adv();
    idle_in();
    sample(); chk("alu_v3", 64'(mem_to_wb_reg_valid), 64'(1));
    chk("alu_p3", 64'(out_payload), 64'h33);
    chk("alu_rdata0", 64'(out_rdata), 64'(0));
    adv();
    sample(); chk("alu_empty", 64'(mem_to_wb_reg_valid), 64'(0));
    adv();

    // 2: lh signed with 3-cycle grant delay, plus extension corner cases
    run_load("lh", 32'h102, 3'd1, 1'b0, 3, 32'h8123_4567, 32'hFFFF_8123);
    run_load("lb", 32'h003, 3'd0, 1'b0, 1, 32'h8000_0000, 32'hFFFF_FF80);
    run_load("lbu", 32'h001, 3'd0, 1'b1, 1, 32'h0000_F0F0, 32'h0000_00F0);
    run_load("lhu", 32'h000, 3'd1, 1'b1, 2, 32'h1234_ABCD, 32'h0000_ABCD);
    run_load("lw", 32'h004, 3'd2, 1'b0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // 3: sb at byte offset 3
    offer(42'h44, 1'b0, 1'b1, 3'd0, 1'b0, 32'h203, 32'h0000_00AB);
    adv();
    idle_in();
    dmem_gnt = 1'b1;
    sample();
    chk("sb_req", 64'(dmem_req), 64'(1));
    chk("sb_we", 64'(dmem_we), 64'(1));
    chk("sb_wstrb", 64'(dmem_wstrb), 64'h8);
    chk("sb_wdata", 64'(dmem_wdata), 64'hABAB_ABAB);
    chk("sb_addr", 64'(dmem_addr), 64'h200);
    adv();
    dmem_gnt = 1'b0;
    sample();
    chk("sb_noreq", 64'(dmem_req), 64'(0));
    chk("sb_valid", 64'(mem_to_wb_reg_valid), 64'(1));
    chk("sb_rdata", 64'(out_rdata), 64'(0));
    adv();

    // 3b: sh at offset 2
    offer(42'h45, 1'b0, 1'b1, 3'd1, 1'b0, 32'h402, 32'h1234_5678);
    adv();
    idle_in();
    dmem_gnt = 1'b1;
    sample();
    chk("sh_wstrb", 64'(dmem_wstrb), 64'hC);
    chk("sh_wdata", 64'(dmem_wdata), 64'h5678_5678);
    adv();
    dmem_gnt = 1'b0;
    adv();

    // 4: misaligned lw
    offer(42'h4A, 1'b1, 1'b0, 3'd2, 1'b0, 32'h101, 32'h0);
    adv();
    idle_in();
    sample();
    chk("mis_req", 64'(dmem_req), 64'(0));
    chk("mis_valid", 64'(mem_to_wb_reg_valid), 64'(1));
    chk("mis_flag", 64'(out_misalign), 64'(1));
    chk("mis_rdata", 64'(out_rdata), 64'(0));
    adv();

    // 5: flush a granted load before rvalid
    offer(42'h55, 1'b1, 1'b0, 3'd2, 1'b0, 32'h300, 32'h0);
    adv();
    idle_in();
    dmem_gnt = 1'b1;
    adv();
    dmem_gnt = 1'b0;
    flush = 1'b1;
    offer(42'h5F, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("fl_allow", 64'(ex_mem_reg_allow_in), 64'(0));
    chk("fl_valid", 64'(mem_to_wb_reg_valid), 64'(0));
    adv();
    flush = 1'b0;
    idle_in();
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    sample();
    chk("drain_valid", 64'(mem_to_wb_reg_valid), 64'(0));
    chk("drain_req", 64'(dmem_req), 64'(0));
    chk("drain_allow", 64'(ex_mem_reg_allow_in), 64'(0));
    adv();
    dmem_rvalid = 1'b0;
    offer(42'h66, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    sample(); chk("post_fl_allow", 64'(ex_mem_reg_allow_in), 64'(1));
    adv();
    idle_in();
    sample();
    chk("post_fl_valid", 64'(mem_to_wb_reg_valid), 64'(1));
    chk("post_fl_payload", 64'(out_payload), 64'h66);
    chk("post_fl_rdata", 64'(out_rdata), 64'(0));
    adv();

    // 6: back-pressure in HOLD
    mem_wb_reg_allow_in = 1'b0;
    offer(42'h77, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    adv();
    offer(42'h88, 1'b1, 1'b0, 3'd2, 1'b0, 32'h500, 32'h0);
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("bp_valid", 64'(mem_to_wb_reg_valid), 64'(1));
      chk("bp_payload", 64'(out_payload), 64'h77);
      chk("bp_allow", 64'(ex_mem_reg_allow_in), 64'(0));
      chk("bp_req", 64'(dmem_req), 64'(0));
      adv();
    end
    idle_in();
    mem_wb_reg_allow_in = 1'b1;
    sample(); chk("bp_release", 64'(ex_mem_reg_allow_in), 64'(1));
    adv();
    sample(); chk("bp_empty", 64'(mem_to_wb_reg_valid), 64'(0));
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
